// File: rtl/ramb4_bitwr_pkg.sv
// Shared widths, FSM state type and pointer helper for the RAMB4 bit-write
// controller (1-bit port A writer, 8-bit port B reader).
package ramb4_bitwr_pkg;

  localparam int BYTE_AW = 9;   // byte address width seen by port B
  localparam int BIT_AW  = 12;  // bit address width seen by port A
  localparam int PTR_W   = 10;  // {wrap, byte_addr}

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PAD  = 1'b1
  } wr_state_e;

  // Writer is a full lap ahead of the reader: same byte address, opposite wrap.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wr,
                                    input logic [PTR_W-1:0] rd);
    return (wr[BYTE_AW-1:0] == rd[BYTE_AW-1:0]) && (wr[PTR_W-1] != rd[PTR_W-1]);
  endfunction

endpackage

// File: rtl/ramb4_ptr_cmp.sv
// Committed-pointer comparator: occupancy and full flag between the write
// pointer and the reader's pointer, both {wrap, byte_addr}.
module ramb4_ptr_cmp
  import ramb4_bitwr_pkg::*;
(
  input  logic [PTR_W-1:0] WR_PTR,
  input  logic [PTR_W-1:0] RD_PTR,
  output logic             FULL,
  output logic [PTR_W-1:0] BYTES_AVAIL
);

  // Modular difference reads 512 exactly when the wrap bits differ on equal addresses.
  assign BYTES_AVAIL = WR_PTR - RD_PTR;
  assign FULL        = ptr_full(WR_PTR, RD_PTR);

endmodule

// File: rtl/ramb4_bit_wr_ctrl.sv
// Serial-bit write controller for a 4 Kb S1/S8 dual-port block RAM.
// Bits land at ADDRA = {byte_addr, bit_idx}; completed bytes are published on
// WR_PTR two cycles after their last bit is accepted. FLUSH closes a partial
// byte by padding the remaining bit positions.
// Optional build macro RAMB4_WR_OVF_CNT_EN adds OVF_CNT, a saturating count of
// cycles with BIT_VALID high while FULL.
module ramb4_bit_wr_ctrl
  import ramb4_bitwr_pkg::*;
#(
  parameter int ZERO_PAD = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BIT_IN,
  input  logic              BIT_VALID,
  output logic              BIT_READY,
  input  logic              FLUSH,
  input  logic [PTR_W-1:0]  RD_PTR,
  output logic [BIT_AW-1:0] ADDRA,
  output logic              DIA,
  output logic              ENA,
  output logic              WEA,
  output logic [PTR_W-1:0]  WR_PTR,
  output logic [PTR_W-1:0]  BYTES_AVAIL,
`ifdef RAMB4_WR_OVF_CNT_EN
  output logic [7:0]        OVF_CNT,
`endif
  output logic              FULL
);

  localparam logic PAD_BIT = (ZERO_PAD != 0) ? 1'b0 : 1'b1;

  wr_state_e         r_state;
  logic [2:0]        r_bit_idx;
  logic [PTR_W-1:0]  r_fill_ptr;   // byte currently being filled (may lead WR_PTR)
  logic [PTR_W-1:0]  r_wr_ptr;     // committed byte pointer
  logic              r_commit;     // last bit of a byte was written this cycle
  logic [BIT_AW-1:0] r_addra;
  logic              r_dia;
  logic              r_ena;
  logic              r_bit_ready;

  wr_state_e         w_state_next;
  logic [2:0]        w_bit_idx_next;
  logic [PTR_W-1:0]  w_fill_ptr_next;
  logic              w_bit_ready_next;
  logic              w_accept;
  logic              w_wr;
  logic              w_wr_bit;
  logic              w_byte_done;
  logic              w_full;

  assign w_accept = BIT_VALID && r_bit_ready;

  // Next-state and write-issue decode; a same-cycle bit is counted before FLUSH is evaluated.
  always_comb begin
    w_state_next     = r_state;
    w_wr             = 1'b0;
    w_wr_bit         = BIT_IN;
    w_bit_idx_next   = r_bit_idx;
    w_fill_ptr_next  = r_fill_ptr;
    w_byte_done      = 1'b0;
    w_bit_ready_next = 1'b0;

    if (r_state == ST_PAD) begin
      w_wr     = 1'b1;
      w_wr_bit = PAD_BIT;
    end else begin
      w_wr     = w_accept;
      w_wr_bit = BIT_IN;
    end

    if (w_wr) begin
      w_bit_idx_next = r_bit_idx + 3'd1;
    end
    w_byte_done = w_wr && (r_bit_idx == 3'd7);
    if (w_byte_done) begin
      w_fill_ptr_next = r_fill_ptr + 10'd1;
    end

    if (r_state == ST_FILL) begin
      if (FLUSH && (w_bit_idx_next != 3'd0)) begin
        w_state_next = ST_PAD;
      end
    end else begin
      if (r_bit_idx == 3'd7) begin
        w_state_next = ST_FILL;
      end
    end

    // Gate on the fill pointer so a byte still awaiting commit already counts toward full.
    w_bit_ready_next = (w_state_next == ST_FILL) && !ptr_full(w_fill_ptr_next, RD_PTR);
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fill position, ready flag and the registered port-A write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bit_idx   <= 3'd0;
      r_fill_ptr  <= '0;
      r_bit_ready <= 1'b0;
      r_addra     <= '0;
      r_dia       <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      r_bit_idx   <= w_bit_idx_next;
      r_fill_ptr  <= w_fill_ptr_next;
      r_bit_ready <= w_bit_ready_next;
      r_ena       <= w_wr;
      if (w_wr) begin
        r_addra <= {r_fill_ptr[BYTE_AW-1:0], r_bit_idx};
        r_dia   <= w_wr_bit;
      end
    end
  end

  // Publish a byte one cycle after its last bit reaches the RAM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_commit <= 1'b0;
      r_wr_ptr <= '0;
    end else begin
      r_commit <= w_byte_done;
      if (r_commit) begin
        r_wr_ptr <= r_wr_ptr + 10'd1;
      end
    end
  end

  ramb4_ptr_cmp u_ptr_cmp (
    .WR_PTR      (r_wr_ptr),
    .RD_PTR      (RD_PTR),
    .FULL        (w_full),
    .BYTES_AVAIL (BYTES_AVAIL)
  );

`ifdef RAMB4_WR_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  // Count cycles where the source offers a bit while the buffer is full; saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf_cnt <= 8'd0;
    end else if (BIT_VALID && w_full && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign OVF_CNT = r_ovf_cnt;
`endif

  assign BIT_READY = r_bit_ready;
  assign ADDRA     = r_addra;
  assign DIA       = r_dia;
  assign ENA       = r_ena;
  assign WEA       = r_ena;
  assign WR_PTR    = r_wr_ptr;
  assign FULL      = w_full;

endmodule

// File: tb/tb_ramb4_bit_wr_ctrl.sv
// Scoreboard bench for ramb4_bit_wr_ctrl: stimulus pushes expected port-A
// writes and expected committed pointers; monitors pop and compare whenever
// the DUT writes or moves WR_PTR. Build with RAMB4_WR_OVF_CNT_EN to cover OVF_CNT.
module tb_ramb4_bit_wr_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        BIT_IN = 1'b0;
  logic        BIT_VALID = 1'b0;
  logic        BIT_READY;
  logic        FLUSH = 1'b0;
  logic [9:0]  RD_PTR = 10'd0;
  logic [11:0] ADDRA;
  logic        DIA;
  logic        ENA;
  logic        WEA;
  logic [9:0]  WR_PTR;
  logic [9:0]  BYTES_AVAIL;
  logic        FULL;
`ifdef RAMB4_WR_OVF_CNT_EN
  logic [7:0]  OVF_CNT;
`endif

  ramb4_bit_wr_ctrl #(.ZERO_PAD(1)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BIT_IN      (BIT_IN),
    .BIT_VALID   (BIT_VALID),
    .BIT_READY   (BIT_READY),
    .FLUSH       (FLUSH),
    .RD_PTR      (RD_PTR),
    .ADDRA       (ADDRA),
    .DIA         (DIA),
    .ENA         (ENA),
    .WEA         (WEA),
    .WR_PTR      (WR_PTR),
    .BYTES_AVAIL (BYTES_AVAIL),
`ifdef RAMB4_WR_OVF_CNT_EN
    .OVF_CNT     (OVF_CNT),
`endif
    .FULL        (FULL)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] wq[$];          // expected {ADDRA, DIA}
  logic [9:0]  cq[$];          // expected WR_PTR after each commit
  logic [11:0] exp_addr = '0;
  logic [9:0]  exp_wp   = '0;
  logic        follow   = 1'b0;
  logic        ram[0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] byte_at(input int n);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = ram[n*8 + k];
    return v;
  endfunction

  // Behavioural RAM port A.
  initial begin
    forever begin
      @(posedge CLK);
      if (ENA && WEA) ram[ADDRA] = DIA;
    end
  end

  // Write monitor.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N && ENA) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {19'd0, ADDRA, DIA}, 32'hFFFF_FFFF);
        end else begin
          e = wq.pop_front();
          chk("port_a_write", {18'd0, WEA, ADDRA, DIA}, {18'd0, 1'b1, e});
        end
      end
    end
  end

  // Commit monitor.
  initial begin
    logic [9:0] last_wp;
    last_wp = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        last_wp = '0;
      end else if (WR_PTR != last_wp) begin
        if (cq.size() == 0) chk("unexpected_commit", WR_PTR, last_wp);
        else chk("commit_ptr", WR_PTR, cq.pop_front());
        last_wp = WR_PTR;
      end
    end
  end

  // Reader that consumes everything as soon as it is committed.
  initial begin
    forever begin
      @(negedge CLK);
      if (follow) RD_PTR = WR_PTR;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_write(input logic b);
    wq.push_back({exp_addr, b});
    if (exp_addr[2:0] == 3'd7) begin
      exp_wp = exp_wp + 10'd1;
      cq.push_back(exp_wp);
    end
    exp_addr = exp_addr + 12'd1;
  endtask

  task automatic send_bit(input logic b);
    int g;
    g = 0;
    BIT_IN = b;
    BIT_VALID = 1'b1;
    while (!BIT_READY && g < 200) begin
      @(negedge CLK);
      g++;
    end
    if (!BIT_READY) begin
      chk("ready_timeout", BIT_READY, 1);
      BIT_VALID = 1'b0;
    end else begin
      push_write(b);
      @(negedge CLK);
      BIT_VALID = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) send_bit(v[k]);
  endtask

  task automatic push_pads();
    while (exp_addr[2:0] != 3'd0) push_write(1'b0);
  endtask

  task automatic do_reset();
    repeat (4) @(negedge CLK);
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    RST_N = 1'b0;
    BIT_VALID = 1'b0;
    FLUSH = 1'b0;
    follow = 1'b0;
    RD_PTR = '0;
    wq.delete();
    cq.delete();
    exp_addr = '0;
    exp_wp = '0;
    #1;
    chk("rst_wr_ptr", WR_PTR, 0);
    chk("rst_addra", ADDRA, 0);
    chk("rst_dia", DIA, 0);
    chk("rst_ena_wea", {ENA, WEA}, 0);
    chk("rst_ready", BIT_READY, 0);
`ifdef RAMB4_WR_OVF_CNT_EN
    chk("rst_ovf_cnt", OVF_CNT, 0);
`endif
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", BIT_READY, 1);
  endtask

  initial begin
    logic [7:0] v;
    int zeros;

    do_reset();
    chk("rst_full", FULL, 0);
    chk("rst_avail", BYTES_AVAIL, 0);

    // Full byte 1,0,1,1,0,0,1,0 -> 0x4D at byte 0, commit two cycles after last bit.
    v = 8'h4D;
    send_byte(v);
    chk("wr_ptr_t1", WR_PTR, 0);
    @(negedge CLK);
    chk("wr_ptr_t2", WR_PTR, 1);
    chk("byte0_4d", byte_at(0), 8'h4D);
    chk("avail_1", BYTES_AVAIL, 1);

    // Three ones then FLUSH: pad 3..7 with zero, 5 cycles not ready, byte 0x07.
    do_reset();
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    FLUSH = 1'b1;
    push_pads();
    @(negedge CLK);
    FLUSH = 1'b0;
    zeros = 0;
    for (int k = 0; k < 20; k++) begin
      if (BIT_READY) break;
      zeros++;
      FLUSH = (zeros == 2);   // stray FLUSH during padding must be ignored
      @(negedge CLK);
    end
    FLUSH = 1'b0;
    chk("pad_not_ready_cycles", zeros, 5);
    chk("pad_wr_ptr_before", WR_PTR, 0);
    @(negedge CLK);
    chk("pad_wr_ptr_after", WR_PTR, 1);
    chk("byte0_07", byte_at(0), 8'h07);

    // FLUSH on a byte boundary does nothing.
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_noop_ready", BIT_READY, 1);

    // Bit accepted together with FLUSH is kept, then padded: 1,0,1 -> 0x05.
    send_bit(1'b1);
    send_bit(1'b0);
    FLUSH = 1'b1;
    send_bit(1'b1);
    FLUSH = 1'b0;
    push_pads();
    repeat (10) @(negedge CLK);
    chk("byte1_05", byte_at(1), 8'h05);
    chk("flush_bit_wr_ptr", WR_PTR, 2);

    // Reset mid-byte discards the partial byte; next bit restarts at ADDRA 0.
    do_reset();
    for (int k = 0; k < 5; k++) send_bit(k[0]);
    do_reset();
    repeat (3) @(negedge CLK);
    chk("mid_rst_wr_ptr", WR_PTR, 0);
    send_bit(1'b1);
    repeat (2) @(negedge CLK);

    // Fill all 512 bytes with the reader parked at 0.
    do_reset();
    for (int n = 0; n < 512; n++) begin
      v = n[7:0] ^ 8'hA5;
      send_byte(v);
    end
    repeat (3) @(negedge CLK);
    chk("full_flag", FULL, 1);
    chk("full_avail", BYTES_AVAIL, 512);
    chk("full_ready", BIT_READY, 0);
    chk("full_wr_ptr", WR_PTR, 10'h200);
    chk("byte1ff", byte_at(511), 8'h5A);
    BIT_VALID = 1'b1;
`ifdef RAMB4_WR_OVF_CNT_EN
    repeat (300) @(negedge CLK);
    chk("ovf_cnt_sat", OVF_CNT, 255);
`else
    repeat (5) @(negedge CLK);
`endif
    BIT_VALID = 1'b0;
    RD_PTR = 10'd1;
    #1;
    chk("rd1_full", FULL, 0);
    chk("rd1_avail", BYTES_AVAIL, 511);
    chk("rd1_ready_same", BIT_READY, 0);
    @(negedge CLK);
    chk("rd1_ready_next", BIT_READY, 1);

    // 513 bytes with a reader that keeps up: byte 512 lands at address 0 with wrap set.
    do_reset();
    follow = 1'b1;
    for (int n = 0; n < 513; n++) begin
      v = n[7:0] ^ 8'hA5;
      send_byte(v);
    end
    repeat (4) @(negedge CLK);
    follow = 1'b0;
    chk("wrap_wr_ptr", WR_PTR, 10'h201);
    chk("wrap_byte0", byte_at(0), 8'hA5);

    repeat (4) @(negedge CLK);
    chk("final_wq_drained", wq.size(), 0);
    chk("final_cq_drained", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ramb4_bit_wr_ctrl.md
RAMB4_BIT_WR_CTRL -- requirements
Module: ramb4_bit_wr_ctrl

Purpose: single-clock write controller that packs a serial bit stream into the 1-bit port A of a 4 Kb S1/S8 dual-port block RAM and publishes committed byte pointers to the 8-bit port-B reader.

Interface
REQ-001 SHALL have parameter ZERO_PAD, default 1, meaning FLUSH pads a partial byte with 0 (1) or 1 (0).
REQ-002 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-004 SHALL have port BIT_IN  in  1  serial data bit.
REQ-005 SHALL have port BIT_VALID  in  1  BIT_IN is valid.
REQ-006 SHALL have port BIT_READY  out  1  bit accepted when VALID and READY.
REQ-007 SHALL have port FLUSH  in  1  single-cycle pulse; close the partial byte.
REQ-008 SHALL have port RD_PTR  in  10  reader byte pointer {wrap, addr[8:0]}.
REQ-009 SHALL have port ADDRA  out  12  RAM port-A bit address.
REQ-010 SHALL have port DIA  out  1  RAM port-A write data.
REQ-011 SHALL have ports ENA and WEA  out  1 each  RAM port-A enable and write enable.
REQ-012 SHALL have port WR_PTR  out  10  committed byte pointer {wrap, addr[8:0]}.
REQ-013 SHALL have port BYTES_AVAIL  out  10  WR_PTR - RD_PTR, range 0..512.
REQ-014 SHALL have port FULL  out  1  512 committed bytes are unread.

Function
REQ-015 SHALL use bit mapping ADDRA = {byte_addr[8:0], bit_idx[2:0]}, with bit k of byte n read at DOB[k] of ADDRB n; bit_idx runs 0..7.
REQ-016 SHALL register ADDRA, DIA, ENA and WEA: a bit accepted in cycle t is written with ENA=WEA=1 in cycle t+1; otherwise ENA=WEA=0.
REQ-017 SHALL advance WR_PTR by 1 (mod 1024) in cycle t+2 after the bit with bit_idx=7 is accepted in cycle t.
REQ-018 SHALL assert FULL when WR_PTR[8:0]==RD_PTR[8:0] and WR_PTR[9]!=RD_PTR[9].
REQ-019 SHALL compute BYTES_AVAIL combinationally as the 10-bit modular difference, and FULL implies BYTES_AVAIL=512.
REQ-020 SHALL set BIT_READY = !FULL and state==FILL, while no commit is pending toward full.
REQ-021 SHALL use FSM states FILL and PAD:
- FILL->PAD on FLUSH when bit_idx (after any same-cycle accepted bit) is nonzero.
- PAD writes the pad bit at each remaining index, one per cycle, with BIT_READY=0.
- PAD->FILL after index 7 is written; the byte is then committed per REQ-017 timing.
REQ-022 SHALL treat FLUSH with bit_idx==0 in FILL as a no-op, and SHALL ignore FLUSH while in PAD.
REQ-023 SHALL handle a bit accepted in the same cycle as FLUSH before the flush.
REQ-024 SHALL wrap byte_addr 511->0 and toggle the wrap bit.
REQ-025 SHALL treat RD_PTR as a same-clock input and SHALL NOT check it for exceeding WR_PTR.

Reset
REQ-026 SHALL, on RST_N low, set asynchronously: WR_PTR=0, bit_idx=0, state=FILL, ADDRA=0, DIA=0, ENA=0, WEA=0, BIT_READY=0.
REQ-027 SHALL, on reset mid-byte or mid-PAD, discard the partial byte and never commit it.
REQ-028 SHALL drive BIT_READY from the cycle after RST_N deasserts, subject to REQ-020.

Configuration
REQ-029 SHALL, with RAMB4_WR_OVF_CNT_EN defined, add output OVF_CNT[7:0]: a saturating count of cycles where BIT_VALID=1 and FULL=1, reset to 0.
REQ-030 SHALL, without RAMB4_WR_OVF_CNT_EN, omit the OVF_CNT port and its logic entirely.

Structure
REQ-031 SHALL place BYTE_AW=9, BIT_AW=12, PTR_W=10 and the FSM state enum in package ramb4_bitwr_pkg.
REQ-032 SHALL implement the full/avail arithmetic in sub-module ramb4_ptr_cmp (inputs WR_PTR and RD_PTR; outputs FULL and BYTES_AVAIL).

Verification
REQ-033 SHALL verify: 8 bits 1,0,1,1,0,0,1,0 with RD_PTR=0 -> ADDRA 0..7 written; WR_PTR=1 two cycles after the last bit; byte 0x4D on DOB.
REQ-034 SHALL verify: 3 bits 1,1,1 then FLUSH -> PAD writes 0 at ADDRA 3..7; byte 0x07; WR_PTR=1; BIT_READY=0 for 5 cycles.
REQ-035 SHALL verify: 4096 bits with RD_PTR=0 -> FULL=1, BYTES_AVAIL=512, BIT_READY=0; then RD_PTR=1 -> BIT_READY=1 next cycle.
REQ-036 SHALL verify: 513 bytes written while the reader advances -> byte_addr wraps to 0 and WR_PTR[9] toggles.
REQ-037 SHALL verify: RST_N low after 5 bits -> WR_PTR stays 0 and the next accepted bit is written at ADDRA 0.
REQ-038 SHALL verify, with RAMB4_WR_OVF_CNT_EN: FULL held with BIT_VALID=1 for 300 cycles -> OVF_CNT=255.
